// File: rtl/sram_dual_fifo_arbiter.sv
// Two ring FIFOs (FIFO_I: slave->master, FIFO_O: master->slave) sharing one async single-port SRAM,
// round-robin arbitrated. Optional error statistics enabled by defining SRAM_FIFO_ERRSTAT_EN.
module sram_dual_fifo_arbiter #(
  parameter int DW     = 16,
  parameter int AW     = 18,
  parameter int DLOG2  = 10,
  parameter int I_BASE = 0,
  parameter int O_BASE = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slv_wr_req,
  input  logic [DW-1:0]    slv_wr_data,
  input  logic             slv_rd_req,
  output logic [DW-1:0]    slv_rd_data,
  output logic             slv_ack,
  input  logic             mst_wr_req,
  input  logic [DW-1:0]    mst_wr_data,
  input  logic             mst_rd_req,
  output logic [DW-1:0]    mst_rd_data,
  output logic             mst_ack,
  output logic             fifo_i_empty,
  output logic             fifo_i_full,
  output logic [DLOG2:0]   fifo_i_count,
  output logic             fifo_o_empty,
  output logic             fifo_o_full,
  output logic [DLOG2:0]   fifo_o_count,
  output logic [AW-1:0]    mem_addr,
  inout  wire  [DW-1:0]    mem_dq,
  output logic             CE_n,
  output logic             OE_n,
  output logic             WE_n,
  output logic             LB_n,
  output logic             UB_n
`ifdef SRAM_FIFO_ERRSTAT_EN
  ,
  output logic             err_ovf,
  output logic             err_udf,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int CW = DLOG2 + 1;
  localparam logic [DLOG2:0] DEPTH = {1'b1, {DLOG2{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_ACK} state_t;

  state_t           state_reg, state_next;
  logic             grant_mst_reg;
  logic             op_wr_reg;
  logic             fifo_o_reg;
  logic             last_mst_reg;
  logic             mask_valid_reg;
  logic [AW-1:0]    addr_reg;
  logic [DW-1:0]    wr_data_reg;
  logic [DW-1:0]    slv_rd_data_reg, mst_rd_data_reg;
  logic             dq_oe;

  logic [1:0][DLOG2-1:0] wr_ptr_w, rd_ptr_w;
  logic [1:0][DLOG2:0]   count_w;
  logic [1:0]            empty_w, full_w;

  logic             slv_act, mst_act, any_act;
  logic             pick_mst, pick_wr, pick_fifo_o, pick_legal;
  logic [DLOG2-1:0] pick_ptr;
  logic [AW-1:0]    pick_addr;

  // The port that was just acked sits out the first IDLE cycle after its ACK.
  always_comb begin
    slv_act     = (slv_wr_req | slv_rd_req) & ~(mask_valid_reg & ~grant_mst_reg);
    mst_act     = (mst_wr_req | mst_rd_req) & ~(mask_valid_reg & grant_mst_reg);
    any_act     = slv_act | mst_act;
    pick_mst    = mst_act & (~slv_act | ~last_mst_reg);
    pick_wr     = pick_mst ? mst_wr_req : slv_wr_req;
    pick_fifo_o = pick_mst ~^ pick_wr;
    pick_legal  = pick_wr ? ~full_w[pick_fifo_o] : ~empty_w[pick_fifo_o];
    pick_ptr    = pick_wr ? wr_ptr_w[pick_fifo_o] : rd_ptr_w[pick_fifo_o];
    pick_addr   = (pick_fifo_o ? AW'(O_BASE) : AW'(I_BASE)) + AW'(pick_ptr);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:   if (any_act) state_next = pick_legal ? ST_SETUP : ST_ACK;
      ST_SETUP:  state_next = ST_STROBE;
      ST_STROBE: state_next = ST_ACK;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    CE_n    = 1'b1;
    OE_n    = 1'b1;
    WE_n    = 1'b1;
    dq_oe   = 1'b0;
    slv_ack = 1'b0;
    mst_ack = 1'b0;
    case (state_reg)
      ST_SETUP: begin
        CE_n  = 1'b0;
        dq_oe = op_wr_reg;
      end
      ST_STROBE: begin
        CE_n  = 1'b0;
        dq_oe = op_wr_reg;
        WE_n  = ~op_wr_reg;
        OE_n  = op_wr_reg;
      end
      ST_ACK: begin
        slv_ack = ~grant_mst_reg;
        mst_ack = grant_mst_reg;
      end
      default: ;
    endcase
  end

  assign LB_n        = CE_n;
  assign UB_n        = CE_n;
  assign mem_addr    = addr_reg;
  assign mem_dq      = dq_oe ? wr_data_reg : {DW{1'bz}};
  assign slv_rd_data = slv_rd_data_reg;
  assign mst_rd_data = mst_rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_mst_reg   <= 1'b0;
      op_wr_reg       <= 1'b0;
      fifo_o_reg      <= 1'b0;
      last_mst_reg    <= 1'b1;
      mask_valid_reg  <= 1'b0;
      addr_reg        <= '0;
      wr_data_reg     <= '0;
      slv_rd_data_reg <= '0;
      mst_rd_data_reg <= '0;
    end else begin
      mask_valid_reg <= (state_reg == ST_ACK);
      if (state_reg == ST_IDLE && any_act) begin
        grant_mst_reg <= pick_mst;
        op_wr_reg     <= pick_wr;
        fifo_o_reg    <= pick_fifo_o;
        last_mst_reg  <= pick_mst;
        wr_data_reg   <= pick_mst ? mst_wr_data : slv_wr_data;
        if (pick_legal) addr_reg <= pick_addr;
      end
      if (state_reg == ST_STROBE && !op_wr_reg) begin
        if (grant_mst_reg) mst_rd_data_reg <= mem_dq;
        else               slv_rd_data_reg <= mem_dq;
      end
    end
  end

  // Index 0 is FIFO_I, index 1 is FIFO_O; state moves only at the STROBE->ACK edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DLOG2-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [DLOG2:0]   count_reg;
      logic             empty_reg, full_reg;
      logic             upd;

      assign upd = (state_reg == ST_STROBE) && (fifo_o_reg == 1'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          empty_reg  <= 1'b1;
          full_reg   <= 1'b0;
        end else if (upd) begin
          if (op_wr_reg) begin
            wr_ptr_reg <= wr_ptr_reg + DLOG2'(1);
            count_reg  <= count_reg + CW'(1);
            empty_reg  <= 1'b0;
            full_reg   <= (count_reg == DEPTH - CW'(1));
          end else begin
            rd_ptr_reg <= rd_ptr_reg + DLOG2'(1);
            count_reg  <= count_reg - CW'(1);
            full_reg   <= 1'b0;
            empty_reg  <= (count_reg == CW'(1));
          end
        end
      end

      assign wr_ptr_w[gi] = wr_ptr_reg;
      assign rd_ptr_w[gi] = rd_ptr_reg;
      assign count_w[gi]  = count_reg;
      assign empty_w[gi]  = empty_reg;
      assign full_w[gi]   = full_reg;
    end
  endgenerate

  assign fifo_i_empty = empty_w[0];
  assign fifo_i_full  = full_w[0];
  assign fifo_i_count = count_w[0];
  assign fifo_o_empty = empty_w[1];
  assign fifo_o_full  = full_w[1];
  assign fifo_o_count = count_w[1];

`ifdef SRAM_FIFO_ERRSTAT_EN
  logic       err_ovf_reg, err_udf_reg;
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_reg  <= 1'b0;
      err_udf_reg  <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else if (state_reg == ST_IDLE && any_act && !pick_legal) begin
      if (pick_wr) err_ovf_reg <= 1'b1;
      else         err_udf_reg <= 1'b1;
      if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign err_ovf  = err_ovf_reg;
  assign err_udf  = err_udf_reg;
  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_sram_dual_fifo_arbiter.sv
// Self-checking bench for sram_dual_fifo_arbiter: directed steps plus random traffic checked
// against a queue-based model of the two FIFOs and the round-robin rule.
`timescale 1ns/1ps
module tb_sram_dual_fifo_arbiter;
  localparam int DW = 16, AW = 18, DLOG2 = 2, I_BASE = 0, O_BASE = 1024, DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic slv_wr_req = 1'b0, slv_rd_req = 1'b0, mst_wr_req = 1'b0, mst_rd_req = 1'b0;
  logic [DW-1:0] slv_wr_data = '0, mst_wr_data = '0;
  logic [DW-1:0] slv_rd_data, mst_rd_data;
  logic slv_ack, mst_ack;
  logic fifo_i_empty, fifo_i_full, fifo_o_empty, fifo_o_full;
  logic [DLOG2:0] fifo_i_count, fifo_o_count;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_dq;
  logic CE_n, OE_n, WE_n, LB_n, UB_n;
`ifdef SRAM_FIFO_ERRSTAT_EN
  logic err_ovf, err_udf;
  logic [7:0] drop_cnt;
`endif

  sram_dual_fifo_arbiter #(.DW(DW), .AW(AW), .DLOG2(DLOG2), .I_BASE(I_BASE), .O_BASE(O_BASE)) dut (
    .clk(clk), .rst(rst),
    .slv_wr_req(slv_wr_req), .slv_wr_data(slv_wr_data), .slv_rd_req(slv_rd_req),
    .slv_rd_data(slv_rd_data), .slv_ack(slv_ack),
    .mst_wr_req(mst_wr_req), .mst_wr_data(mst_wr_data), .mst_rd_req(mst_rd_req),
    .mst_rd_data(mst_rd_data), .mst_ack(mst_ack),
    .fifo_i_empty(fifo_i_empty), .fifo_i_full(fifo_i_full), .fifo_i_count(fifo_i_count),
    .fifo_o_empty(fifo_o_empty), .fifo_o_full(fifo_o_full), .fifo_o_count(fifo_o_count),
    .mem_addr(mem_addr), .mem_dq(mem_dq),
    .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .LB_n(LB_n), .UB_n(UB_n)
`ifdef SRAM_FIFO_ERRSTAT_EN
    , .err_ovf(err_ovf), .err_udf(err_udf), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Async SRAM model; tb_probe lets the bench see whether the DUT releases the bus.
  logic [DW-1:0] sram [0:2047];
  logic tb_probe = 1'b0;
  assign mem_dq = tb_probe ? 16'h5A3C : ((!CE_n && !OE_n) ? sram[mem_addr[10:0]] : 'z);
  always @(posedge clk) if (!CE_n && !WE_n) sram[mem_addr[10:0]] <= mem_dq;

  // Reference model
  logic [DW-1:0] q_i[$], q_o[$];
  int wr_tot[2], rd_tot[2];
  bit last_mst;
  logic [DW-1:0] exp_slv_rd, exp_mst_rd;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_i.delete(); q_o.delete();
    wr_tot = '{0, 0}; rd_tot = '{0, 0};
    last_mst = 1'b1; exp_slv_rd = '0; exp_mst_rd = '0;
  endtask

  task automatic model_step(input bit mst, input bit wr, input logic [DW-1:0] d,
                            output bit legal, output int exp_addr);
    bit fo;
    int n;
    logic [DW-1:0] v;
    if (mst) fo = wr; else fo = !wr;
    n = fo ? q_o.size() : q_i.size();
    legal = wr ? (n < DEPTH) : (n > 0);
    exp_addr = (fo ? O_BASE : I_BASE) + ((wr ? wr_tot[fo] : rd_tot[fo]) % DEPTH);
    last_mst = mst;
    if (!legal) return;
    if (wr) begin
      if (fo) q_o.push_back(d); else q_i.push_back(d);
      wr_tot[fo]++;
    end else begin
      v = fo ? q_o.pop_front() : q_i.pop_front();
      rd_tot[fo]++;
      if (mst) exp_mst_rd = v; else exp_slv_rd = v;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "/i_cnt"}, fifo_i_count, q_i.size());
    chk({tag, "/i_empty"}, fifo_i_empty, q_i.size() == 0);
    chk({tag, "/i_full"}, fifo_i_full, q_i.size() == DEPTH);
    chk({tag, "/o_cnt"}, fifo_o_count, q_o.size());
    chk({tag, "/o_empty"}, fifo_o_empty, q_o.size() == 0);
    chk({tag, "/o_full"}, fifo_o_full, q_o.size() == DEPTH);
    chk({tag, "/slv_rd"}, slv_rd_data, exp_slv_rd);
    chk({tag, "/mst_rd"}, mst_rd_data, exp_mst_rd);
  endtask

  task automatic access(input bit mst, input bit wr, input logic [DW-1:0] d, input string tag);
    bit legal, got;
    int exp_addr, lat, we_seen, oe_seen, addr_seen;
    @(negedge clk); @(negedge clk);
    model_step(mst, wr, d, legal, exp_addr);
    if (mst) begin mst_wr_req = wr; mst_rd_req = !wr; mst_wr_data = d; end
    else     begin slv_wr_req = wr; slv_rd_req = !wr; slv_wr_data = d; end
    got = 0; lat = 0; we_seen = 0; oe_seen = 0; addr_seen = -1;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (!WE_n) begin we_seen++; addr_seen = int'(mem_addr); end
      if (!OE_n) begin oe_seen++; addr_seen = int'(mem_addr); end
      if (mst ? mst_ack : slv_ack) begin got = 1; lat = c; end
    end
    slv_wr_req = 0; slv_rd_req = 0; mst_wr_req = 0; mst_rd_req = 0;
    $display("access %s: mst=%0b wr=%0b data=%h legal=%0b lat=%0d addr=%0d", tag, mst, wr, d, legal, lat, addr_seen);
    chk({tag, "/lat"}, lat, legal ? 3 : 1);
    chk({tag, "/we"}, we_seen, (legal && wr) ? 1 : 0);
    chk({tag, "/oe"}, oe_seen, (legal && !wr) ? 1 : 0);
    if (legal) chk({tag, "/addr"}, addr_seen, exp_addr);
    chk_model(tag);
  endtask

  task automatic pair(input bit sw, input logic [DW-1:0] sd, input bit mw, input logic [DW-1:0] md,
                      input string tag);
    bit first_mst, l1, l2;
    int a1, a2, exp1, exp2, ts, tm;
    @(negedge clk); @(negedge clk);
    first_mst = !last_mst;
    if (first_mst) begin model_step(1, mw, md, l1, a1); model_step(0, sw, sd, l2, a2); end
    else           begin model_step(0, sw, sd, l1, a1); model_step(1, mw, md, l2, a2); end
    exp1 = l1 ? 3 : 1;
    exp2 = exp1 + 1 + (l2 ? 3 : 1);
    slv_wr_req = sw; slv_rd_req = !sw; slv_wr_data = sd;
    mst_wr_req = mw; mst_rd_req = !mw; mst_wr_data = md;
    ts = 0; tm = 0;
    for (int c = 1; c <= 20 && (ts == 0 || tm == 0); c++) begin
      @(negedge clk);
      if (slv_ack && ts == 0) begin ts = c; slv_wr_req = 0; slv_rd_req = 0; end
      if (mst_ack && tm == 0) begin tm = c; mst_wr_req = 0; mst_rd_req = 0; end
    end
    slv_wr_req = 0; slv_rd_req = 0; mst_wr_req = 0; mst_rd_req = 0;
    $display("pair %s: sw=%0b mw=%0b first_mst=%0b slv_lat=%0d mst_lat=%0d", tag, sw, mw, first_mst, ts, tm);
    chk({tag, "/slv_lat"}, ts, first_mst ? exp2 : exp1);
    chk({tag, "/mst_lat"}, tm, first_mst ? exp1 : exp2);
    chk_model(tag);
  endtask

  initial begin
    model_reset();
    // 1. reset state
    repeat (3) @(negedge clk);
    chk("rst/CE_n", CE_n, 1); chk("rst/OE_n", OE_n, 1); chk("rst/WE_n", WE_n, 1);
    chk("rst/LB_n", LB_n, 1); chk("rst/UB_n", UB_n, 1);
    chk("rst/addr", mem_addr, 0);
    chk("rst/slv_ack", slv_ack, 0); chk("rst/mst_ack", mst_ack, 0);
    tb_probe = 1'b1; #1;
    chk("rst/dq_released", mem_dq, 16'h5A3C);
    tb_probe = 1'b0;
    chk_model("rst");
    rst = 1'b0;

    // 2. single write then read back through the master
    access(0, 1, 16'hA5A5, "t2_wr");
    chk("t2/sram", sram[I_BASE], 16'hA5A5);
    access(1, 0, 16'h0000, "t2_rd");

    // 3. contention: slave first, then master first after a lone slave access
    pair(1, 16'h1111, 1, 16'h2222, "t3_pairA");
    access(0, 0, 16'h0000, "t3_slv_rd");
    pair(1, 16'h3333, 1, 16'h4444, "t3_pairB");

    // 5. reset during STROBE of a write
    @(negedge clk); @(negedge clk);
    slv_wr_req = 1; slv_wr_data = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    chk("t5/we_low", WE_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5/we_rel", WE_n, 1); chk("t5/ce_rel", CE_n, 1); chk("t5/no_ack", slv_ack, 0);
    chk("t5/i_cnt", fifo_i_count, 0); chk("t5/o_cnt", fifo_o_count, 0);
    slv_wr_req = 0;
    @(negedge clk);
    chk("t5/no_ack2", slv_ack, 0);
    rst = 1'b0;
    model_reset();

`ifdef SRAM_FIFO_ERRSTAT_EN
    // 6. two reads of an empty FIFO_O
    access(0, 0, 16'h0000, "t6_udf1");
    access(0, 0, 16'h0000, "t6_udf2");
    chk("t6/err_udf", err_udf, 1); chk("t6/err_ovf", err_ovf, 0); chk("t6/drop_cnt", drop_cnt, 2);
`endif

    // 4. fill, overflow, wrap
    for (int k = 1; k <= 4; k++) access(0, 1, DW'(k), "t4_fill");
    access(0, 1, 16'h0005, "t4_ovf");
`ifdef SRAM_FIFO_ERRSTAT_EN
    chk("t4/err_ovf", err_ovf, 1); chk("t4/drop_cnt", drop_cnt, 3);
`endif
    access(1, 0, 16'h0000, "t4_rd1");
    access(1, 0, 16'h0000, "t4_rd2");
    access(0, 1, 16'h0005, "t4_wr5");
    access(0, 1, 16'h0006, "t4_wr6");
    for (int k = 0; k < 4; k++) access(1, 0, 16'h0000, "t4_drain");

    // random traffic
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0)
        pair(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), "rnd_pair");
      else
        access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
